// File: rtl/trap_controller_pkg.sv
// Shared definitions for the user-mode trap controller: cause codes, ustatus
// bit positions, FSM encoding and the ustatus update helpers.
package trap_controller_pkg;

  localparam int NEXC = 9;

  localparam logic [4:0] CAUSE_SW    = 5'd0;
  localparam logic [4:0] CAUSE_TIMER = 5'd4;
  localparam logic [4:0] CAUSE_EXT   = 5'd8;

  localparam int IRQ_SW    = 0;
  localparam int IRQ_TIMER = 1;
  localparam int IRQ_EXT   = 2;

  localparam int US_UIE  = 0;
  localparam int US_UPIE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRCSR = 2'd1,
    ST_REDIR = 2'd2,
    ST_RET   = 2'd3
  } trap_state_t;

  function automatic logic [31:0] ustatus_on_trap(input logic [31:0] us);
    logic [31:0] r;
    r          = us;
    r[US_UPIE] = us[US_UIE];
    r[US_UIE]  = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] ustatus_on_ret(input logic [31:0] us);
    logic [31:0] r;
    r          = us;
    r[US_UIE]  = us[US_UPIE];
    r[US_UPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_controller_priority_enc.sv
// Combinational trap arbiter: picks the winning exception or interrupt and
// reports which pending bit would be consumed if the trap is taken.
module trap_controller_priority_enc
  import trap_controller_pkg::*;
#(
  parameter int NIRQ = 3
) (
  input  logic [NEXC-1:0] exc_vec,
  input  logic [NIRQ-1:0] pending,
  input  logic [NIRQ-1:0] irq_en,
  input  logic            uie,
  output logic            take,
  output logic            is_irq,
  output logic [4:0]      code,
  output logic [NIRQ-1:0] irq_clr
);

  logic [NIRQ-1:0] active;
  assign active = pending & irq_en;

  always_comb begin
    take    = 1'b0;
    is_irq  = 1'b0;
    code    = 5'd0;
    irq_clr = '0;
    if (|exc_vec) begin
      take = 1'b1;
      // Scan downwards so the lowest set index is the last one written.
      for (int k = NEXC - 1; k >= 0; k--) begin
        if (exc_vec[k]) code = 5'(k);
      end
    end else if (uie && (|active)) begin
      take   = 1'b1;
      is_irq = 1'b1;
      if (active[IRQ_EXT]) begin
        code             = CAUSE_EXT;
        irq_clr[IRQ_EXT] = 1'b1;
      end else if (active[IRQ_SW]) begin
        code            = CAUSE_SW;
        irq_clr[IRQ_SW] = 1'b1;
      end else begin
        code               = CAUSE_TIMER;
        irq_clr[IRQ_TIMER] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_controller.sv
// User-mode trap controller: decides traps/URET at commit, sequences the CSR
// writes and the fetch redirect, and keeps the latched interrupt-pending bits.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int          NIRQ        = 3,
  parameter logic [31:0] RESET_UTVEC = 32'h0000_0000
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iCommit,
  input  logic [31:0]     iPC,
  input  logic [31:0]     iNextPC,
  input  logic [8:0]      iExcVec,
  input  logic            iURET,
  input  logic [NIRQ-1:0] iIRQ,
  input  logic [31:0]     iUSTATUS,
  input  logic [31:0]     iUIE,
  input  logic [31:0]     iUTVEC,
  input  logic [31:0]     iUEPC,
  output logic            oUCAUSEWrite,
  output logic [31:0]     oUCAUSEData,
  output logic            oUEPCWrite,
  output logic [31:0]     oUEPCData,
  output logic            oUSTATUSWrite,
  output logic [31:0]     oUSTATUSData,
  output logic            oRedirect,
  output logic [31:0]     oRedirectPC,
  output logic            oStall,
  output logic [NIRQ-1:0] oPending
);

  trap_state_t     state_q, state_d;
  logic [NIRQ-1:0] irq_q, pending_q, pending_d;
  logic            is_irq_q;
  logic [4:0]      code_q;

  logic            take, is_irq;
  logic [4:0]      code;
  logic [NIRQ-1:0] irq_clr, irq_en;
  logic            trap_go;

  logic            ucause_wr_d, uepc_wr_d, ustatus_wr_d, redirect_d;
  logic [31:0]     ucause_data_d, uepc_data_d, ustatus_data_d, redirect_pc_d;
  logic [31:0]     utvec_eff, trap_pc;

  logic unused_uie;
  assign unused_uie = ^{iUIE[31:9], iUIE[7:5], iUIE[3:1]};

  assign irq_en = {iUIE[8], iUIE[4], iUIE[0]};

  trap_controller_priority_enc #(.NIRQ(NIRQ)) u_prio (
    .exc_vec (iExcVec),
    .pending (pending_q),
    .irq_en  (irq_en),
    .uie     (iUSTATUS[US_UIE]),
    .take    (take),
    .is_irq  (is_irq),
    .code    (code),
    .irq_clr (irq_clr)
  );

  assign trap_go = (state_q == ST_IDLE) && iCommit && take;

  // A fresh edge in the take cycle wins over the clear.
  assign pending_d = (pending_q & ~(trap_go ? irq_clr : '0)) | (iIRQ & ~irq_q);

  assign utvec_eff = (iUTVEC == 32'd0) ? RESET_UTVEC : iUTVEC;
  assign trap_pc   = {utvec_eff[31:2], 2'b00} +
                     (((utvec_eff[1:0] == 2'b01) && is_irq_q) ? {25'd0, code_q, 2'b00} : 32'd0);

  always_comb begin
    state_d        = state_q;
    ucause_wr_d    = 1'b0;
    ucause_data_d  = 32'd0;
    uepc_wr_d      = 1'b0;
    uepc_data_d    = 32'd0;
    ustatus_wr_d   = 1'b0;
    ustatus_data_d = 32'd0;
    redirect_d     = 1'b0;
    redirect_pc_d  = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (trap_go) begin
          state_d        = ST_WRCSR;
          ucause_wr_d    = 1'b1;
          ucause_data_d  = {is_irq, 26'd0, code};
          uepc_wr_d      = 1'b1;
          uepc_data_d    = is_irq ? iNextPC : iPC;
          ustatus_wr_d   = 1'b1;
          ustatus_data_d = ustatus_on_trap(iUSTATUS);
        end else if (iCommit && iURET) begin
          state_d        = ST_RET;
          ustatus_wr_d   = 1'b1;
          ustatus_data_d = ustatus_on_ret(iUSTATUS);
          redirect_d     = 1'b1;
          redirect_pc_d  = iUEPC;
        end
      end
      ST_WRCSR: begin
        state_d       = ST_REDIR;
        redirect_d    = 1'b1;
        redirect_pc_d = trap_pc;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are the registered image of the state being entered.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q       <= ST_IDLE;
      irq_q         <= '0;
      pending_q     <= '0;
      is_irq_q      <= 1'b0;
      code_q        <= 5'd0;
      oUCAUSEWrite  <= 1'b0;
      oUCAUSEData   <= 32'd0;
      oUEPCWrite    <= 1'b0;
      oUEPCData     <= 32'd0;
      oUSTATUSWrite <= 1'b0;
      oUSTATUSData  <= 32'd0;
      oRedirect     <= 1'b0;
      oRedirectPC   <= 32'd0;
    end else begin
      state_q       <= state_d;
      irq_q         <= iIRQ;
      pending_q     <= pending_d;
      if (trap_go) begin
        is_irq_q <= is_irq;
        code_q   <= code;
      end
      oUCAUSEWrite  <= ucause_wr_d;
      oUCAUSEData   <= ucause_data_d;
      oUEPCWrite    <= uepc_wr_d;
      oUEPCData     <= uepc_data_d;
      oUSTATUSWrite <= ustatus_wr_d;
      oUSTATUSData  <= ustatus_data_d;
      oRedirect     <= redirect_d;
      oRedirectPC   <= redirect_pc_d;
    end
  end

  assign oStall   = (state_q != ST_IDLE);
  assign oPending = pending_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: exceptions, interrupts, URET, reset and
// pending-bit corner cases, with hand-computed expected values.
module tb_trap_controller;

  logic        iCLK = 1'b0;
  logic        iRST, iCommit, iURET;
  logic [31:0] iPC, iNextPC, iUSTATUS, iUIE, iUTVEC, iUEPC;
  logic [8:0]  iExcVec;
  logic [2:0]  iIRQ;
  logic        oUCAUSEWrite, oUEPCWrite, oUSTATUSWrite, oRedirect, oStall;
  logic [31:0] oUCAUSEData, oUEPCData, oUSTATUSData, oRedirectPC;
  logic [2:0]  oPending;
  logic [4:0]  strb;

  int n_chk = 0;
  int n_fail = 0;

  always #5 iCLK = ~iCLK;

  assign strb = {oUCAUSEWrite, oUEPCWrite, oUSTATUSWrite, oRedirect, oStall};

  trap_controller #(.NIRQ(3), .RESET_UTVEC(32'h0000_0000)) dut (
    .iCLK(iCLK), .iRST(iRST), .iCommit(iCommit), .iPC(iPC), .iNextPC(iNextPC),
    .iExcVec(iExcVec), .iURET(iURET), .iIRQ(iIRQ), .iUSTATUS(iUSTATUS),
    .iUIE(iUIE), .iUTVEC(iUTVEC), .iUEPC(iUEPC),
    .oUCAUSEWrite(oUCAUSEWrite), .oUCAUSEData(oUCAUSEData),
    .oUEPCWrite(oUEPCWrite), .oUEPCData(oUEPCData),
    .oUSTATUSWrite(oUSTATUSWrite), .oUSTATUSData(oUSTATUSData),
    .oRedirect(oRedirect), .oRedirectPC(oRedirectPC),
    .oStall(oStall), .oPending(oPending)
  );

  task automatic step();
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic test_reset();
    iRST = 1'b1; iCommit = 1'b0; iURET = 1'b0; iPC = 32'd0; iNextPC = 32'd0;
    iExcVec = 9'd0; iIRQ = 3'd0; iUSTATUS = 32'd0; iUIE = 32'd0;
    iUTVEC = 32'h1000; iUEPC = 32'd0;
    step(); step();
    n_chk++;
    if ({strb, oPending} !== 8'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected %b", {strb, oPending}, 8'd0);
    end
    n_chk++;
    if ({oUCAUSEData, oUEPCData, oUSTATUSData, oRedirectPC} !== 128'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {oUCAUSEData, oUEPCData, oUSTATUSData, oRedirectPC});
    end
    iRST = 1'b0;
    step();
  endtask

  task automatic test_no_commit();
    iExcVec = 9'b0_0000_0010; iCommit = 1'b0;
    step();
    n_chk++;
    if (strb !== 5'b00000) begin
      n_fail++; $display("FAIL no_commit_idle: got %b expected %b", strb, 5'b00000);
    end
    iExcVec = 9'd0;
  endtask

  task automatic test_exception();
    iUSTATUS = 32'h1; iUTVEC = 32'h1000; iPC = 32'h400; iNextPC = 32'h404;
    iExcVec = 9'b1_0000_0100; iCommit = 1'b1;
    step();
    iCommit = 1'b0; iExcVec = 9'd0;
    n_chk++;
    if (strb !== 5'b11101) begin
      n_fail++; $display("FAIL exc_wrcsr_strobes: got %b expected %b", strb, 5'b11101);
    end
    n_chk++;
    if ({oUCAUSEData, oUEPCData, oUSTATUSData} !== {32'd2, 32'h400, 32'h10}) begin
      n_fail++; $display("FAIL exc_wrcsr_data: got %h %h %h expected 2 400 10", oUCAUSEData, oUEPCData, oUSTATUSData);
    end
    step();
    n_chk++;
    if ({strb, oRedirectPC} !== {5'b00011, 32'h1000}) begin
      n_fail++; $display("FAIL exc_redir: got %b %h expected 00011 1000", strb, oRedirectPC);
    end
    step();
    n_chk++;
    if (strb !== 5'b00000) begin
      n_fail++; $display("FAIL exc_back_idle: got %b expected %b", strb, 5'b00000);
    end
  endtask

  task automatic test_irq_vectored();
    iUSTATUS = 32'h1; iUIE = 32'h100; iUTVEC = 32'h1001;
    iIRQ = 3'b100;
    step();
    n_chk++;
    if (oPending !== 3'b100) begin
      n_fail++; $display("FAIL irq_pending_set: got %b expected %b", oPending, 3'b100);
    end
    iCommit = 1'b1; iPC = 32'h200; iNextPC = 32'h204;
    step();
    iCommit = 1'b0;
    n_chk++;
    if ({strb, oUCAUSEData, oUEPCData} !== {5'b11101, 32'h8000_0008, 32'h204}) begin
      n_fail++; $display("FAIL irq_wrcsr: got %b %h %h expected 11101 80000008 204", strb, oUCAUSEData, oUEPCData);
    end
    n_chk++;
    if (oPending !== 3'b000) begin
      n_fail++; $display("FAIL irq_pending_clear: got %b expected %b", oPending, 3'b000);
    end
    step();
    n_chk++;
    if ({oRedirect, oRedirectPC} !== {1'b1, 32'h1020}) begin
      n_fail++; $display("FAIL irq_vector_target: got %b %h expected 1 1020", oRedirect, oRedirectPC);
    end
    step();
    iIRQ = 3'b000; iUTVEC = 32'h1000;
    step();
  endtask

  task automatic test_exc_beats_irq();
    iUSTATUS = 32'h1; iUIE = 32'h1; iIRQ = 3'b001;
    step();
    iCommit = 1'b1; iExcVec = 9'b0_0000_1000; iPC = 32'h500; iNextPC = 32'h504;
    step();
    iCommit = 1'b0; iExcVec = 9'd0;
    n_chk++;
    if ({oUCAUSEData, oUEPCData, oPending} !== {32'd3, 32'h500, 3'b001}) begin
      n_fail++; $display("FAIL beat_exc_first: got %h %h %b expected 3 500 001", oUCAUSEData, oUEPCData, oPending);
    end
    step(); step();
    iCommit = 1'b1; iPC = 32'h504; iNextPC = 32'h508;
    step();
    iCommit = 1'b0;
    n_chk++;
    if ({oUCAUSEData, oUEPCData, oPending} !== {32'h8000_0000, 32'h508, 3'b000}) begin
      n_fail++; $display("FAIL beat_irq_next: got %h %h %b expected 80000000 508 000", oUCAUSEData, oUEPCData, oPending);
    end
    step();
    n_chk++;
    if (oRedirectPC !== 32'h1000) begin
      n_fail++; $display("FAIL beat_direct_target: got %h expected %h", oRedirectPC, 32'h1000);
    end
    step();
    iIRQ = 3'b000;
    step();
  endtask

  task automatic test_priority();
    iUSTATUS = 32'h1; iUIE = 32'h111; iIRQ = 3'b111; iNextPC = 32'h700;
    step();
    iCommit = 1'b1;
    step();
    iCommit = 1'b0;
    n_chk++;
    if ({oUCAUSEData, oPending} !== {32'h8000_0008, 3'b011}) begin
      n_fail++; $display("FAIL prio_ext: got %h %b expected 80000008 011", oUCAUSEData, oPending);
    end
    step(); step();
    iCommit = 1'b1;
    step();
    iCommit = 1'b0;
    n_chk++;
    if ({oUCAUSEData, oPending} !== {32'h8000_0000, 3'b010}) begin
      n_fail++; $display("FAIL prio_sw: got %h %b expected 80000000 010", oUCAUSEData, oPending);
    end
    step(); step();
    iCommit = 1'b1;
    step();
    iCommit = 1'b0;
    n_chk++;
    if ({oUCAUSEData, oPending} !== {32'h8000_0004, 3'b000}) begin
      n_fail++; $display("FAIL prio_timer: got %h %b expected 80000004 000", oUCAUSEData, oPending);
    end
    step(); step();
    iIRQ = 3'b000;
    step();
  endtask

  task automatic test_uret();
    iUSTATUS = 32'h10; iUIE = 32'h10; iIRQ = 3'b010; iUEPC = 32'h300;
    step();
    iCommit = 1'b1;
    step();
    iCommit = 1'b0;
    n_chk++;
    if ({strb, oPending} !== {5'b00000, 3'b010}) begin
      n_fail++; $display("FAIL uret_masked: got %b %b expected 00000 010", strb, oPending);
    end
    iCommit = 1'b1; iURET = 1'b1;
    step();
    iCommit = 1'b0; iURET = 1'b0;
    n_chk++;
    if ({strb, oUSTATUSData, oRedirectPC} !== {5'b00111, 32'h11, 32'h300}) begin
      n_fail++; $display("FAIL uret_ret: got %b %h %h expected 00111 11 300", strb, oUSTATUSData, oRedirectPC);
    end
    step();
    n_chk++;
    if (strb !== 5'b00000) begin
      n_fail++; $display("FAIL uret_one_cycle: got %b expected %b", strb, 5'b00000);
    end
    iUSTATUS = 32'h11; iCommit = 1'b1; iNextPC = 32'h304;
    step();
    iCommit = 1'b0;
    n_chk++;
    if ({oUCAUSEData, oUEPCData, oUSTATUSData} !== {32'h8000_0004, 32'h304, 32'h10}) begin
      n_fail++; $display("FAIL uret_then_irq: got %h %h %h expected 80000004 304 10", oUCAUSEData, oUEPCData, oUSTATUSData);
    end
    step(); step();
    iIRQ = 3'b000;
    step();
  endtask

  task automatic test_reset_in_wrcsr();
    iUSTATUS = 32'h0; iUIE = 32'h100; iIRQ = 3'b100;
    step();
    iCommit = 1'b1; iExcVec = 9'b0_0000_0001; iPC = 32'h800;
    step();
    iCommit = 1'b0; iExcVec = 9'd0;
    n_chk++;
    if ({strb, oPending} !== {5'b11101, 3'b100}) begin
      n_fail++; $display("FAIL rst_pre_wrcsr: got %b %b expected 11101 100", strb, oPending);
    end
    iRST = 1'b1; iIRQ = 3'b000;
    step();
    n_chk++;
    if ({strb, oPending, oUCAUSEData} !== {5'b00000, 3'b000, 32'd0}) begin
      n_fail++; $display("FAIL rst_in_wrcsr: got %b %b %h expected 00000 000 0", strb, oPending, oUCAUSEData);
    end
    iRST = 1'b0;
    step();
    n_chk++;
    if ({strb, oPending} !== 8'd0) begin
      n_fail++; $display("FAIL rst_no_partial: got %b %b expected 00000 000", strb, oPending);
    end
  endtask

  task automatic test_same_cycle_edge();
    iUSTATUS = 32'h1; iUIE = 32'h1; iIRQ = 3'b001;
    step();
    iIRQ = 3'b000;
    step();
    iIRQ = 3'b001; iCommit = 1'b1; iNextPC = 32'h604;
    step();
    iCommit = 1'b0; iUSTATUS = 32'h0;
    n_chk++;
    if ({oUCAUSEData, oPending} !== {32'h8000_0000, 3'b001}) begin
      n_fail++; $display("FAIL edge_on_take: got %h %b expected 80000000 001", oUCAUSEData, oPending);
    end
    step(); step();
    n_chk++;
    if ({strb, oPending} !== {5'b00000, 3'b001}) begin
      n_fail++; $display("FAIL edge_on_take_idle: got %b %b expected 00000 001", strb, oPending);
    end
  endtask

  initial begin
    test_reset();
    test_no_commit();
    test_exception();
    test_irq_vectored();
    test_exc_beats_irq();
    test_priority();
    test_uret();
    test_reset_in_wrcsr();
    test_same_cycle_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
